// File: rtl/ms_bcd_display_if.sv
// Bus between the ms counter side and the BCD display stage.
//   qin    : binary count to convert (0..1023, nominal 0..999)
//   freeze : hold off new conversions
//   bcd    : latched digits {hundreds,tens,ones}
//   valid  : one-cycle pulse when bcd/ovf update
//   ovf    : last converted value exceeded 999
//   seg    : 7-segment pattern {g,f,e,d,c,b,a}, active high
//   an     : one-hot active-low digit enables (an[0]=ones)
interface ms_bcd_display_if;
  logic [9:0]  qin;
  logic        freeze;
  logic [11:0] bcd;
  logic        valid;
  logic        ovf;
  logic [6:0]  seg;
  logic [2:0]  an;

  modport master (output qin, freeze, input bcd, valid, ovf, seg, an);
  modport slave  (input qin, freeze, output bcd, valid, ovf, seg, an);
endinterface

// File: rtl/ms_bcd_display.sv
// Display stage for the 0..999 ms counter: samples qin, converts it to three BCD
// digits with a sequential double-dabble engine (12-cycle refresh), and scans the
// digits onto a single 7-segment driver.
// Ports: clk, clrn (async active-low reset), bus (ms_bcd_display_if.slave).
// Parameter SCAN_DIV: clk cycles per digit slot (>=1).
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zero digits (seg only).
module ms_bcd_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              clrn,
  ms_bcd_display_if.slave   bus
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  logic [1:0]  state, state_nxt;
  logic [9:0]  sr;
  logic [15:0] work, work_adj;
  logic [3:0]  bit_cnt;
  logic [11:0] bcd_r;
  logic        valid_r, ovf_r;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    dig_idx, dig_nxt;
  logic [2:0]    an_r, an_nxt;
  logic [6:0]    seg_r, seg_nxt;
  logic [3:0]    nib;
  logic          blank;

  assign bus.bcd   = bcd_r;
  assign bus.valid = valid_r;
  assign bus.ovf   = ovf_r;
  assign bus.seg   = seg_r;
  assign bus.an    = an_r;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    seg_of = 7'b0111111;
      4'd1:    seg_of = 7'b0000110;
      4'd2:    seg_of = 7'b1011011;
      4'd3:    seg_of = 7'b1001111;
      4'd4:    seg_of = 7'b1100110;
      4'd5:    seg_of = 7'b1101101;
      4'd6:    seg_of = 7'b1111101;
      4'd7:    seg_of = 7'b0000111;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1101111;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state; SHIFT runs exactly 10 cycles (bit_cnt 0..9)
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!bus.freeze) state_nxt = S_SHIFT;
      S_SHIFT: if (bit_cnt == 4'd9) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Add-3 correction on every nibble before the shift
  always_comb begin
    work_adj = work;
    for (int i = 0; i < 4; i++) begin
      if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath and latched results
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sr      <= '0;
      work    <= '0;
      bit_cnt <= '0;
      bcd_r   <= '0;
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!bus.freeze) begin
            sr      <= bus.qin;
            work    <= '0;
            bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          work    <= {work_adj[14:0], sr[9]};
          sr      <= {sr[8:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
        end
        S_LATCH: begin
          valid_r <= 1'b1;
          // A nonzero thousands digit means qin was 1000..1023
          if (work[15:12] != 4'd0) begin
            bcd_r <= 12'h999;
            ovf_r <= 1'b1;
          end else begin
            bcd_r <= work[11:0];
            ovf_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Pattern for the digit that the next slot will drive
  always_comb begin
    dig_nxt = (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
    case (dig_nxt)
      2'd0:    begin nib = bcd_r[3:0];  an_nxt = 3'b110; end
      2'd1:    begin nib = bcd_r[7:4];  an_nxt = 3'b101; end
      default: begin nib = bcd_r[11:8]; an_nxt = 3'b011; end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    blank = !ovf_r &&
            (((dig_nxt == 2'd2) && (bcd_r[11:8] == 4'd0)) ||
             ((dig_nxt == 2'd1) && (bcd_r[11:4] == 8'd0)));
`else
    blank = 1'b0;
`endif
    if (ovf_r)      seg_nxt = SEG_DASH;
    else if (blank) seg_nxt = SEG_BLANK;
    else            seg_nxt = seg_of(nib);
  end

  // Digit scan: advance digit, an and seg together on terminal count
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
      an_r     <= 3'b110;
      seg_r    <= 7'b0111111;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig_idx  <= dig_nxt;
      an_r     <= an_nxt;
      seg_r    <= seg_nxt;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_ms_bcd_display.sv
// Testbench for ms_bcd_display (SCAN_DIV=4): table vectors, random values against
// a decimal-arithmetic model, and hand-written freeze/reset/timing sequences.
module tb_ms_bcd_display;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  ms_bcd_display_if bus ();
  ms_bcd_display #(.SCAN_DIV(4)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0]  q;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;
  vec_t tab[10];

  logic [6:0] seg_tab [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model_bcd(input int q);
    if (q > 999) return 12'h999;
    return {4'(q / 100), 4'((q / 10) % 10), 4'(q % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input logic o, input int d);
    logic [3:0] n;
    n = b[4*d +: 4];
    if (o) return 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 2 && b[11:8] == 4'd0) return 7'b0000000;
    if (d == 1 && b[11:8] == 4'd0 && b[7:4] == 4'd0) return 7'b0000000;
`endif
    if (n > 4'd9) return 7'b0000000;
    return seg_tab[n];
  endfunction

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.valid) ok = 1'b1;
    end
  endtask

  // Change qin and wait until a conversion of the new value has latched
  task automatic apply_q(input logic [9:0] q);
    bit ok;
    bus.qin = q;
    wait_valid(14, ok);
    check("valid_a", 32'(ok), 32'd1);
    wait_valid(14, ok);
    check("valid_b", 32'(ok), 32'd1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_seg"},   32'(bus.seg),   32'(7'b0111111));
    check({name, "_an"},    32'(bus.an),    32'(3'b110));
    check({name, "_bcd"},   32'(bus.bcd),   32'd0);
    check({name, "_valid"}, 32'(bus.valid), 32'd0);
    check({name, "_ovf"},   32'(bus.ovf),   32'd0);
  endtask

  // Align to a slot boundary, then verify 12 cycles of scan (3 slots x 4 cycles)
  task automatic check_scan(input logic [11:0] b, input logic o);
    logic [2:0] prev;
    logic [2:0] pat [3];
    bit moved;
    int d0, d;
    pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;
    prev = bus.an;
    moved = 1'b0;
    for (int i = 0; i < 8 && !moved; i++) begin
      @(negedge clk);
      if (bus.an != prev) moved = 1'b1;
    end
    check("scan_align", 32'(moved), 32'd1);
    d0 = (bus.an == 3'b110) ? 0 : (bus.an == 3'b101) ? 1 : 2;
    for (int i = 0; i < 12; i++) begin
      d = (d0 + i / 4) % 3;
      check($sformatf("scan_%0d", i), 32'({bus.an, bus.seg}), 32'({pat[d], exp_seg(b, o, d)}));
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int first, second, nvalid;
    logic [9:0] q;

    seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    tab[0] = '{10'd457,  12'h457, 1'b0};
    tab[1] = '{10'd1023, 12'h999, 1'b1};
    tab[2] = '{10'd7,    12'h007, 1'b0};
    tab[3] = '{10'd0,    12'h000, 1'b0};
    tab[4] = '{10'd999,  12'h999, 1'b0};
    tab[5] = '{10'd1000, 12'h999, 1'b1};
    tab[6] = '{10'd123,  12'h123, 1'b0};
    tab[7] = '{10'd89,   12'h089, 1'b0};
    tab[8] = '{10'd640,  12'h640, 1'b0};
    tab[9] = '{10'd510,  12'h510, 1'b0};

    clrn = 1'b0;
    bus.qin = 10'd999;
    bus.freeze = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("reset");

    // Valid lands 11 cycles after the capture edge and repeats every 12
    clrn = 1'b1;
    first = -1; second = -1; nvalid = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        nvalid++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("valid_first", 32'(first), 32'd11);
    check("valid_second", 32'(second), 32'd23);
    check("valid_count", 32'(nvalid), 32'd2);
    check("bcd_999", 32'(bus.bcd), 32'h999);
    check("ovf_999", 32'(bus.ovf), 32'd0);

    foreach (tab[i]) begin
      apply_q(tab[i].q);
      check($sformatf("tab%0d_bcd", i), 32'(bus.bcd), 32'(tab[i].bcd));
      check($sformatf("tab%0d_ovf", i), 32'(bus.ovf), 32'(tab[i].ovf));
      check_scan(tab[i].bcd, tab[i].ovf);
    end

    for (int i = 0; i < 20; i++) begin
      q = 10'($urandom_range(0, 1023));
      apply_q(q);
      check($sformatf("rnd%0d_bcd(q=%0d)", i, q), 32'(bus.bcd), 32'(model_bcd(int'(q))));
      check($sformatf("rnd%0d_ovf(q=%0d)", i, q), 32'(bus.ovf), 32'(q > 10'd999));
      if (i % 5 == 0) check_scan(model_bcd(int'(q)), q > 10'd999);
    end

    // Freeze right after a latch: no new conversions, value held
    apply_q(10'd123);
    bus.freeze = 1'b1;
    bus.qin = 10'd456;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
    end
    check("freeze_no_valid", 32'(nvalid), 32'd0);
    check("freeze_bcd", 32'(bus.bcd), 32'h123);
    bus.freeze = 1'b0;
    wait_valid(13, ok);
    check("unfreeze_valid", 32'(ok), 32'd1);
    check("unfreeze_bcd", 32'(bus.bcd), 32'h456);

    // Asynchronous reset in the middle of SHIFT aborts the conversion
    apply_q(10'd321);
    repeat (4) @(negedge clk);
    #2 clrn = 1'b0;
    #1 check_reset("midshift");
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
    end
    check("midshift_no_valid", 32'(nvalid), 32'd0);
    check("midshift_bcd", 32'(bus.bcd), 32'd0);
    clrn = 1'b1;
    wait_valid(14, ok);
    check("after_reset_valid", 32'(ok), 32'd1);
    check("after_reset_bcd", 32'(bus.bcd), 32'h321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
